// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: picks one fetch redirect per cycle and tracks in-flight icache reads
// so that responses belonging to a squashed path are flagged for discard.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int MAX_OUTSTANDING = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        excp_valid,
    input  logic [31:0] excp_target,
    input  logic        ertn_valid,
    input  logic [31:0] ertn_target,
    input  logic        bju_mispredict,
    input  logic [31:0] bju_target,
    input  logic [1:0]  bp_taken,
    input  logic [31:0] bp_target,
    input  logic        fb_full,
    input  logic        icache_fire,
    input  logic        icache_rvalid,
    output logic        pc_flush,
    output logic [31:0] pc_new_pc,
    output logic        pc_pause,
    output logic [1:0]  pc_taken_sure,
    output logic [31:0] pc_pre_addr,
    output logic        resp_drop
);
    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;
    localparam logic [1:0] MAX = 2'(MAX_OUTSTANDING);
    state_t state, state_next;
    logic [1:0] cnt, cnt_next, drop_cnt, drop_cnt_next;
    logic redirect_any, inc, dec;
    logic [31:0] target;
    assign redirect_any = excp_valid | ertn_valid | bju_mispredict;
    assign target = excp_valid ? excp_target : ertn_valid ? ertn_target : bju_target;
    // saturating counter: a fire at the cap or a return at zero is ignored
    assign inc = icache_fire && cnt != MAX;
    assign dec = icache_rvalid && cnt != 2'd0;
    assign cnt_next = cnt + {1'b0, inc} - {1'b0, dec};
    // a redirect marks every read still outstanding after this cycle as stale
    assign drop_cnt_next = redirect_any ? cnt_next : drop_cnt - {1'b0, resp_drop};
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end
    always_comb begin
        state_next = redirect_any ? FLUSH :
                     (state != IDLE && drop_cnt_next != 2'd0) ? DRAIN : IDLE;
    end
    always_comb begin
        resp_drop = icache_rvalid && drop_cnt != 2'd0;
        pc_pause = fb_full || cnt == MAX || state != IDLE || redirect_any;
        pc_taken_sure = pc_pause ? 2'b00 : bp_taken;
        pc_pre_addr = bp_target;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 2'd0;
            drop_cnt  <= 2'd0;
            pc_flush  <= 1'b0;
            pc_new_pc <= RESET_PC;
        end else begin
            cnt      <= cnt_next;
            drop_cnt <= drop_cnt_next;
            pc_flush <= redirect_any;
            if (redirect_any) pc_new_pc <= target;
        end
    end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed and random checks of fetch_redirect_ctrl against a
// counter-based behavioural model.
module tb_fetch_redirect_ctrl;
    logic        clk, rst;
    logic        excp_valid, ertn_valid, bju_mispredict;
    logic [31:0] excp_target, ertn_target, bju_target, bp_target;
    logic [1:0]  bp_taken;
    logic        fb_full, icache_fire, icache_rvalid;
    logic        pc_flush, pc_pause, resp_drop;
    logic [31:0] pc_new_pc, pc_pre_addr;
    logic [1:0]  pc_taken_sure;

    int compared = 0;
    int mismatched = 0;
    int m_cnt, m_drop;
    bit m_flush;
    logic [31:0] m_pc;
    bit armed = 0;

    fetch_redirect_ctrl dut (
        .clk(clk), .rst(rst),
        .excp_valid(excp_valid), .excp_target(excp_target),
        .ertn_valid(ertn_valid), .ertn_target(ertn_target),
        .bju_mispredict(bju_mispredict), .bju_target(bju_target),
        .bp_taken(bp_taken), .bp_target(bp_target),
        .fb_full(fb_full), .icache_fire(icache_fire), .icache_rvalid(icache_rvalid),
        .pc_flush(pc_flush), .pc_new_pc(pc_new_pc), .pc_pause(pc_pause),
        .pc_taken_sure(pc_taken_sure), .pc_pre_addr(pc_pre_addr), .resp_drop(resp_drop)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        excp_valid = 0; ertn_valid = 0; bju_mispredict = 0;
        bp_taken = 0; fb_full = 0; icache_fire = 0; icache_rvalid = 0;
    endtask

    function automatic bit model_pause();
        return fb_full || m_cnt == 3 || m_flush || m_drop != 0 ||
               excp_valid || ertn_valid || bju_mispredict;
    endfunction

    // checks every output against the model, then advances the model across one edge
    task automatic tick();
        bit redir, xp, xd;
        int n;
        @(negedge clk);
        redir = excp_valid || ertn_valid || bju_mispredict;
        xp = model_pause();
        xd = icache_rvalid && m_drop > 0;
        if (armed) begin
            chk("pause", pc_pause, xp);
            chk("taken_sure", pc_taken_sure, xp ? 2'b00 : bp_taken);
            chk("resp_drop", resp_drop, xd);
            chk("pre_addr", pc_pre_addr, bp_target);
            chk("flush", pc_flush, m_flush);
            chk("new_pc", pc_new_pc, m_pc);
        end
        if (rst) begin
            m_cnt = 0; m_drop = 0; m_flush = 0; m_pc = 32'h1c000000;
        end else begin
            n = m_cnt + ((icache_fire && m_cnt < 3) ? 1 : 0) - ((icache_rvalid && m_cnt > 0) ? 1 : 0);
            m_drop = redir ? n : m_drop - (xd ? 1 : 0);
            m_cnt = n;
            m_flush = redir;
            if (redir) m_pc = excp_valid ? excp_target : ertn_valid ? ertn_target : bju_target;
        end
        @(posedge clk);
        #1;
    endtask

    // three reads outstanding, redirect, then one stale response: DRAIN with drop_cnt=2
    task automatic setup_drain2();
        idle_in(); icache_fire = 1;
        repeat (3) tick();
        idle_in(); bju_mispredict = 1; bju_target = 32'h1c000100;
        tick();
        idle_in(); tick();
        icache_rvalid = 1; tick();
        idle_in();
    endtask

    initial begin
        idle_in(); rst = 1;
        excp_target = 0; ertn_target = 0; bju_target = 0; bp_target = 0;
        m_cnt = 0; m_drop = 0; m_flush = 0; m_pc = 32'h1c000000;
        repeat (2) tick();
        armed = 1;
        rst = 0; #1;
        chk("rst_flush", pc_flush, 1'b0);
        chk("rst_pause", pc_pause, 1'b0);
        chk("rst_new_pc", pc_new_pc, 32'h1c000000);
        chk("rst_resp_drop", resp_drop, 1'b0);
        tick();

        bp_taken = 2'b01; bp_target = 32'h1c000040; #1;
        chk("bp_pass", pc_taken_sure, 2'b01);
        chk("bp_addr", pc_pre_addr, 32'h1c000040);
        bju_mispredict = 1; #1;
        chk("bp_gated", pc_taken_sure, 2'b00);
        bju_mispredict = 0;
        tick();

        idle_in();
        excp_valid = 1; ertn_valid = 1; bju_mispredict = 1;
        excp_target = 32'h1c001000; ertn_target = 32'h1c002000; bju_target = 32'h1c003000;
        tick();
        idle_in(); #1;
        chk("prio_flush", pc_flush, 1'b1);
        chk("prio_pc", pc_new_pc, 32'h1c001000);
        tick();
        chk("prio_pulse", pc_flush, 1'b0);

        icache_fire = 1;
        repeat (3) tick();
        idle_in(); #1;
        chk("cap_pause", pc_pause, 1'b1);
        bju_mispredict = 1; bju_target = 32'h1c000100;
        tick();
        idle_in(); #1;
        chk("bju_pc", pc_new_pc, 32'h1c000100);
        tick();
        icache_rvalid = 1;
        for (int i = 0; i < 3; i++) begin
            #1; chk("drain_drop", resp_drop, 1'b1);
            tick();
        end
        #1;
        chk("drain_done", resp_drop, 1'b0);
        chk("drain_unpause", pc_pause, 1'b0);
        tick();

        setup_drain2();
        excp_valid = 1; excp_target = 32'h1c008000;
        tick();
        idle_in(); #1;
        chk("reflush", pc_flush, 1'b1);
        chk("reflush_pc", pc_new_pc, 32'h1c008000);
        tick();
        icache_rvalid = 1;
        for (int i = 0; i < 2; i++) begin
            #1; chk("reload_drop", resp_drop, 1'b1);
            tick();
        end
        #1; chk("reload_done", resp_drop, 1'b0);
        tick();

        setup_drain2();
        rst = 1; tick();
        rst = 0; icache_rvalid = 1; #1;
        chk("rst_drain_drop", resp_drop, 1'b0);
        chk("rst_drain_pc", pc_new_pc, 32'h1c000000);
        chk("rst_drain_pause", pc_pause, 1'b0);
        tick();

        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(99) == 0);
            excp_valid = ($urandom_range(11) == 0);
            ertn_valid = ($urandom_range(11) == 0);
            bju_mispredict = ($urandom_range(7) == 0);
            excp_target = $urandom; ertn_target = $urandom; bju_target = $urandom;
            bp_taken = 2'($urandom); bp_target = $urandom;
            fb_full = ($urandom_range(3) == 0);
            icache_rvalid = 1'($urandom);
            icache_fire = !model_pause() && 1'($urandom);
            tick();
        end
        rst = 0; idle_in(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
